tuple_hasher: RTL
=================

Name: tuple_hasher

Overview:
- Two-lane ingress stage directly upstream of the 2-input hash distributor (DD2).
- Per lane: computes a 32-bit hash tag from the tuple key and stamps each accepted tuple with a 64-bit serial number.
- Emits a drained end-of-stream indication, last_processed.
- Each lane is an independent 3-stage elastic pipeline with valid/ready backpressure. Its output bundle maps 1:1 onto the distributor's input bundle.

Parameters:
- INPUT_SIZE, 64: tuple width in bits.
- KEY_WIDTH, 32: key field width, taken from in_data[i][KEY_WIDTH-1:0]. Legal range 1..32; keys narrower than 32 are zero-extended.
- SERIAL_BASE, 0: initial serial number of both lanes after reset.

Ports:
- clk  in  1  clock. One clock domain only.
- resetn  in  1  synchronous, active-low reset.
- in_ready  out  [1:0]  lane i accepts a tuple this cycle.
- in_data  in  [1:0][INPUT_SIZE-1:0]  tuple payload.
- in_valid  in  [1:0]  tuple present.
- in_last  in  [1:0]  lane i upstream stream finished (level, sticky until reset).
- in_was_joined  in  [1:0]  passthrough flag.
- out_ready  in  [1:0]  downstream accepts lane i.
- out_data  out  [1:0][INPUT_SIZE-1:0]  payload, unmodified.
- out_tag  out  [1:0][31:0]  hash digest.
- out_valid  out  [1:0]  output tuple present.
- out_last_processed  out  [1:0]  lane i fully drained after end of stream.
- out_serialnum  out  [1:0][63:0]  per-lane acceptance index.
- out_was_joined  out  [1:0]  passthrough of in_was_joined.

Behaviour:
- Lanes 0 and 1 are fully independent. There is no cross-lane ordering or stalling.

Reset:
- Synchronous: sampled only on posedge clk while resetn=0.
- Clears all stage-valid bits, so out_valid=0 and out_last_processed=0.
- Loads both serial counters with SERIAL_BASE. out_tag, out_data and out_serialnum read 0.
- Reset asserted mid-stream discards all in-flight tuples without emitting them.
- in_ready=0 while resetn=0. in_ready becomes 1 in the first cycle after release.

Handshake:
- A transfer occurs on the cycle where valid&ready are both high.
- out_valid, out_data, out_tag, out_serialnum and out_was_joined hold stable while out_valid=1 and out_ready=0.
- in_ready[i] = ~s1_valid | s1_adv, where s1_adv is stage-1 advance.
- in_ready is combinational from pipeline occupancy and out_ready only, never from in_valid.

Pipeline, per lane, stages S1..S3. Each stage has a valid bit. sK advances when ~s(K+1)_valid or s(K+1) advances; S3 advances when out_ready.
- Let k = zero-extended key.
- S1 captures: data, was_joined, serial = counter, h1 = k ^ (k >> 16).
- S2: h2 = (h1 * 32'h85EBCA6B) truncated to 32 bits, then h2 ^= h2 >> 13.
- S3: h3 = (h2 * 32'hC2B2AE35) truncated, then h3 ^= h3 >> 16; out_tag = h3. This is the MurmurHash3 fmix32 finaliser.
- Latency: 3 cycles from accept to out_valid with no stall.
- Throughput: 1 tuple/cycle/lane. Bubbles collapse: with out_ready=0 the lane absorbs exactly 3 tuples, then in_ready drops.

Serial counter:
- Increments by 1 on each accepted input transfer.
- 64-bit, wraps from 2^64-1 to 0 without a flag.

last_processed:
- Set out_last_processed[i] (registered) when in_last[i]=1, all three stage-valid bits are 0, and in_valid[i]=0.
- Sticky until reset.
- A tuple still in flight when in_last rises delays the assertion until that tuple has been transferred out.
- in_valid with in_last already high is an upstream error; the tuple is still accepted and processed.

Test Plan:
- Reset, then key 0 on lane 0 with out_ready=1 -> out_valid[0] exactly 3 cycles after accept; out_tag=32'h00000000; out_serialnum=0; out_data unchanged.
- Stream keys 1..100 on both lanes, out_ready=1 -> 1 output/cycle/lane; out_tag matches the bench fmix32 model; serialnums 0..99 in order; no drops or duplicates.
- Lane 0: 5 valid tuples with out_ready[0]=0 -> exactly 3 accepted; in_ready[0]=0 from the 4th tuple; outputs held stable. out_ready[0]=1 releases the tuples in order. Lane 1 keeps streaming unaffected throughout.
- Random valid/ready toggling for 10k tuples -> scoreboard: ordered, serialnums contiguous, tags correct, was_joined preserved.
- in_last[1]=1 while 2 tuples are in flight and out_ready[1]=0 for 4 cycles -> out_last_processed[1] stays 0 until the 2nd tuple is transferred, then is 1 one cycle later and stays 1.
- SERIAL_BASE=64'hFFFF_FFFF_FFFF_FFFE, 3 tuples -> serials FFFF_FFFF_FFFF_FFFE, FFFF_FFFF_FFFF_FFFF, 0. Then assert resetn=0 with tuples in flight -> next cycle out_valid=0, counter back to SERIAL_BASE.

Source files
------------

// File: rtl/tuple_hasher.sv
// ---------------------------------------------------------------------------
// tuple_hasher
//   Two-lane ingress stage feeding the 2-input hash distributor. Each lane is
//   an independent 3-stage elastic pipeline. It computes the MurmurHash3 fmix32
//   finaliser of the tuple key, one step per stage. It also stamps every
//   accepted tuple with a 64-bit per-lane serial number.
//
// Ports (lane index i in [1:0]):
//   clk                 clock (single domain)
//   resetn              synchronous active-low reset
//   in_valid/in_ready   ingress handshake, per lane
//   in_data             tuple payload; key = in_data[i][KEY_WIDTH-1:0]
//   in_last             sticky end-of-stream level from upstream
//   in_was_joined       flag passed through untouched
//   out_valid/out_ready egress handshake, per lane
//   out_data            payload, unmodified
//   out_tag             32-bit fmix32 digest of the zero-extended key
//   out_serialnum       acceptance index of the tuple within its lane
//   out_was_joined      passthrough of in_was_joined
//   out_last_processed  lane saw end of stream and has fully drained
// ---------------------------------------------------------------------------
module tuple_hasher #(
   parameter int          INPUT_SIZE  = 64,
   parameter int          KEY_WIDTH   = 32,
   parameter logic [63:0] SERIAL_BASE = 64'd0
) (
   input  logic                        clk,
   input  logic                        resetn,
   output logic [1:0]                  in_ready,
   input  logic [1:0][INPUT_SIZE-1:0]  in_data,
   input  logic [1:0]                  in_valid,
   input  logic [1:0]                  in_last,
   input  logic [1:0]                  in_was_joined,
   input  logic [1:0]                  out_ready,
   output logic [1:0][INPUT_SIZE-1:0]  out_data,
   output logic [1:0][31:0]            out_tag,
   output logic [1:0]                  out_valid,
   output logic [1:0]                  out_last_processed,
   output logic [1:0][63:0]            out_serialnum,
   output logic [1:0]                  out_was_joined
);

   localparam logic [31:0] FMIX_C1 = 32'h85EBCA6B;
   localparam logic [31:0] FMIX_C2 = 32'hC2B2AE35;

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic                  s1_valid_reg, s2_valid_reg, s3_valid_reg;
      logic [INPUT_SIZE-1:0] s1_data_reg, s2_data_reg, s3_data_reg;
      logic                  s1_wj_reg, s2_wj_reg, s3_wj_reg;
      logic [63:0]           s1_serial_reg, s2_serial_reg, s3_serial_reg;
      logic [31:0]           s1_hash_reg, s2_hash_reg, s3_hash_reg;
      logic [63:0]           serial_cnt_reg;
      logic                  last_done_reg;

      logic                  s1_load, s2_load, s3_load, accept;
      logic [31:0]           key_ext, h1_next, mul2, h2_next, mul3, h3_next;

      // A stage may load when it is empty or its content moves on this cycle.
      // This chain lets bubbles collapse so a stalled lane holds 3 tuples.
      always_comb begin
         s3_load = ~s3_valid_reg | out_ready[gi];
         s2_load = ~s2_valid_reg | s3_load;
         s1_load = ~s1_valid_reg | s2_load;
      end

      assign in_ready[gi] = resetn & s1_load;
      assign accept       = in_valid[gi] & in_ready[gi];

      // fmix32: one xor-shift or multiply/xor-shift step per stage
      always_comb begin
         key_ext                = '0;
         key_ext[KEY_WIDTH-1:0] = in_data[gi][KEY_WIDTH-1:0];
         h1_next                = key_ext ^ (key_ext >> 16);
         mul2                   = s1_hash_reg * FMIX_C1;
         h2_next                = mul2 ^ (mul2 >> 13);
         mul3                   = s2_hash_reg * FMIX_C2;
         h3_next                = mul3 ^ (mul3 >> 16);
      end

      always_ff @(posedge clk) begin
         if (!resetn) begin
            s1_valid_reg   <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s3_valid_reg   <= 1'b0;
            s1_data_reg    <= '0;
            s2_data_reg    <= '0;
            s3_data_reg    <= '0;
            s1_wj_reg      <= 1'b0;
            s2_wj_reg      <= 1'b0;
            s3_wj_reg      <= 1'b0;
            s1_serial_reg  <= '0;
            s2_serial_reg  <= '0;
            s3_serial_reg  <= '0;
            s1_hash_reg    <= '0;
            s2_hash_reg    <= '0;
            s3_hash_reg    <= '0;
            serial_cnt_reg <= SERIAL_BASE;
            last_done_reg  <= 1'b0;
         end else begin
            if (accept) begin
               serial_cnt_reg <= serial_cnt_reg + 64'd1;
            end

            if (s1_load) begin
               s1_valid_reg <= accept;
               if (accept) begin
                  s1_data_reg   <= in_data[gi];
                  s1_wj_reg     <= in_was_joined[gi];
                  s1_serial_reg <= serial_cnt_reg;
                  s1_hash_reg   <= h1_next;
               end
            end

            if (s2_load) begin
               s2_valid_reg <= s1_valid_reg;
               if (s1_valid_reg) begin
                  s2_data_reg   <= s1_data_reg;
                  s2_wj_reg     <= s1_wj_reg;
                  s2_serial_reg <= s1_serial_reg;
                  s2_hash_reg   <= h2_next;
               end
            end

            // Only load S3 when it frees up, so a stalled output holds stable.
            if (s3_load) begin
               s3_valid_reg <= s2_valid_reg;
               if (s2_valid_reg) begin
                  s3_data_reg   <= s2_data_reg;
                  s3_wj_reg     <= s2_wj_reg;
                  s3_serial_reg <= s2_serial_reg;
                  s3_hash_reg   <= h3_next;
               end
            end

            // Drained only once nothing is in flight or being offered.
            if (in_last[gi] && !s1_valid_reg && !s2_valid_reg && !s3_valid_reg
                && !in_valid[gi]) begin
               last_done_reg <= 1'b1;
            end
         end
      end

      assign out_valid[gi]          = s3_valid_reg;
      assign out_data[gi]           = s3_data_reg;
      assign out_tag[gi]            = s3_hash_reg;
      assign out_serialnum[gi]      = s3_serial_reg;
      assign out_was_joined[gi]     = s3_wj_reg;
      assign out_last_processed[gi] = last_done_reg;
   end

endmodule
